// File: rtl/fetch_unit_pkg.sv
// Shared cpu2 core definitions: fetch geometry, fetch FSM states and the
// opcode field layout that the decoder also uses.
package fetch_unit_pkg;

   localparam int CPU_ADDR_W   = 8;
   localparam int CPU_INSTR_W  = 8;
   localparam int CPU_PROG_LEN = 64;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_e;

   // The opcode sits in the upper nibble of each instruction word.
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_LOAD = 4'h8;
   localparam logic [3:0] OPC_ADD  = 4'h9;
   localparam logic [3:0] OPC_JMP  = 4'hA;
   localparam logic [3:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: the instruction word, its address and valid/ready.
interface fetch_unit_if
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W  = CPU_ADDR_W,
   parameter int INSTR_W = CPU_INSTR_W
) ();

   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               instr_ready;

   modport master (
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );

endinterface

// File: rtl/fetch_unit.sv
// cpu2 instruction fetch: owns the PC, addresses the combinational program ROM
// and hands the registered instruction to the decoder over valid/ready.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W   = CPU_ADDR_W,
   parameter int INSTR_W  = CPU_INSTR_W,
   parameter int PROG_LEN = CPU_PROG_LEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [ADDR_W-1:0]  linenumber,
   input  logic [INSTR_W-1:0] rom_data,
   input  logic               branch_valid,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               halt,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic               fault,
   fetch_unit_if.master       dec
);

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
   localparam logic [ADDR_W:0]   LEN_EXT = (ADDR_W + 1)'(PROG_LEN);

   fetch_state_e       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic               r_valid;
   logic               r_halted;
   logic               r_fault;
   logic               r_halt_pend;

   logic               w_slot_free;
   logic [ADDR_W-1:0]  w_pc_inc;
   logic               w_tgt_ok;

   always_comb begin
      w_slot_free = !r_valid || dec.instr_ready;
      // Wrap at the end of the program rather than running into unused ROM.
      w_pc_inc    = (r_pc == LAST_PC) ? '0 : r_pc + ADDR_W'(1);
      w_tgt_ok    = ({1'b0, branch_target} < LEN_EXT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_pc        <= '0;
         r_instr     <= '0;
         r_instr_pc  <= '0;
         r_valid     <= 1'b0;
         r_halted    <= 1'b0;
         r_fault     <= 1'b0;
         r_halt_pend <= 1'b0;
      end else if (branch_valid) begin
         // A redirect flushes the held word and drops any pending halt.
         r_valid     <= 1'b0;
         r_halt_pend <= 1'b0;
         if (w_tgt_ok) begin
            r_pc     <= branch_target;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
         end else begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
         end
      end else begin
         case (r_state)
            ST_RUN: begin
               if (halt || r_halt_pend) begin
                  // Stop fetching; retire to HALTED once the held word is gone.
                  if (w_slot_free) begin
                     r_state     <= ST_HALTED;
                     r_halted    <= 1'b1;
                     r_valid     <= 1'b0;
                     r_halt_pend <= 1'b0;
                  end else begin
                     r_halt_pend <= 1'b1;
                  end
               end else if (w_slot_free) begin
                  if (en) begin
                     r_instr    <= rom_data;
                     r_instr_pc <= r_pc;
                     r_valid    <= 1'b1;
                     r_pc       <= w_pc_inc;
                  end else begin
                     r_valid    <= 1'b0;
                  end
               end
            end
            ST_HALTED: begin
               r_valid <= 1'b0;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign linenumber      = r_pc;
   assign pc              = r_pc;
   assign halted          = r_halted;
   assign fault           = r_fault;
   assign dec.instr       = r_instr;
   assign dec.instr_pc    = r_instr_pc;
   assign dec.instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 6-word program; expected fetches are
// queued as stimulus is driven and popped when the decoder side presents them.
module tb_fetch_unit;

   localparam int AW = 8;
   localparam int IW = 8;
   localparam int PL = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [AW-1:0] linenumber;
   logic [IW-1:0] rom_data;
   logic          branch_valid = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          halt = 1'b0;
   logic [AW-1:0] pc;
   logic          halted;
   logic          fault;

   logic [IW-1:0] rom [0:PL-1] = '{8'h8F, 8'h8B, 8'h85, 8'h9B, 8'h9D, 8'h97};

   logic [15:0]   exp_q[$];
   int            n_cmp = 0;
   int            n_fail = 0;

   fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) dif ();

   fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .PROG_LEN(PL)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .linenumber    (linenumber),
      .rom_data      (rom_data),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .halt          (halt),
      .pc            (pc),
      .halted        (halted),
      .fault         (fault),
      .dec           (dif)
   );

   always #5 clk = ~clk;

   assign rom_data = (linenumber < AW'(PL)) ? rom[linenumber] : 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_fetch(input logic [AW-1:0] a);
      exp_q.push_back({a, rom[a]});
   endtask

   // Pops the next expected fetch and compares it with what the decoder sees.
   task automatic pop_check(input string tag);
      logic [15:0] e;
      if (exp_q.size() == 0) begin
         check({tag, "_q"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_v"},  32'(dif.instr_valid), 32'd1);
         check({tag, "_i"},  32'(dif.instr),       32'(e[7:0]));
         check({tag, "_pc"}, 32'(dif.instr_pc),    32'(e[15:8]));
      end
   endtask

   initial begin
      dif.instr_ready = 1'b0;
      #1;
      check("rst_pc",    32'(pc),              32'd0);
      check("rst_valid", 32'(dif.instr_valid), 32'd0);
      check("rst_instr", 32'(dif.instr),       32'd0);
      check("rst_ipc",   32'(dif.instr_pc),    32'd0);
      check("rst_halt",  32'(halted),          32'd0);
      check("rst_fault", 32'(fault),           32'd0);
      tick();
      tick();
      rst = 1'b1;
      en = 1'b1;
      dif.instr_ready = 1'b1;

      // stream from reset: one instruction per cycle
      for (int a = 0; a < 4; a++) begin
         push_fetch(AW'(a));
         tick();
         pop_check("stream");
         check("stream_pcnext", 32'(pc), 32'(a + 1));
      end

      branch_valid = 1'b1;
      branch_target = 8'd1;
      tick();
      check("br1_flush", 32'(dif.instr_valid), 32'd0);
      check("br1_pc",    32'(pc),              32'd1);
      branch_valid = 1'b0;
      push_fetch(8'd1);
      tick();
      pop_check("br1_fetch");

      // backpressure on 0x8B
      dif.instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_valid", 32'(dif.instr_valid), 32'd1);
         check("bp_instr", 32'(dif.instr),       32'h8B);
         check("bp_ipc",   32'(dif.instr_pc),    32'd1);
         check("bp_pc",    32'(pc),              32'd2);
         check("bp_addr",  32'(linenumber),      32'd2);
      end
      dif.instr_ready = 1'b1;
      push_fetch(8'd2);
      tick();
      pop_check("bp_release");

      // flush while 0x85 is valid, then stream across the wrap
      branch_valid = 1'b1;
      branch_target = 8'd4;
      tick();
      check("br4_flush", 32'(dif.instr_valid), 32'd0);
      check("br4_pc",    32'(pc),              32'd4);
      branch_valid = 1'b0;
      push_fetch(8'd4);
      push_fetch(8'd5);
      push_fetch(8'd0);
      push_fetch(8'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         pop_check("wrap");
      end
      check("wrap_pc", 32'(pc), 32'd2);

      // halt while the decoder stalls
      dif.instr_ready = 1'b0;
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("hp_valid",  32'(dif.instr_valid), 32'd1);
      check("hp_instr",  32'(dif.instr),       32'h8B);
      check("hp_pc",     32'(pc),              32'd2);
      check("hp_halted", 32'(halted),          32'd0);
      tick();
      check("hp2_pc",     32'(pc),     32'd2);
      check("hp2_halted", 32'(halted), 32'd0);
      dif.instr_ready = 1'b1;
      tick();
      check("h_halted", 32'(halted),          32'd1);
      check("h_valid",  32'(dif.instr_valid), 32'd0);
      check("h_pc",     32'(pc),              32'd2);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      tick();
      check("hh_halted", 32'(halted),          32'd1);
      check("hh_valid",  32'(dif.instr_valid), 32'd0);
      check("hh_pc",     32'(pc),              32'd2);

      branch_valid = 1'b1;
      branch_target = 8'd2;
      tick();
      branch_valid = 1'b0;
      check("resume_halted", 32'(halted), 32'd0);
      check("resume_pc",     32'(pc),     32'd2);
      push_fetch(8'd2);
      tick();
      pop_check("resume");

      // branch and halt together: the branch wins
      branch_valid = 1'b1;
      branch_target = 8'd0;
      halt = 1'b1;
      tick();
      branch_valid = 1'b0;
      halt = 1'b0;
      check("bh_halted", 32'(halted),          32'd0);
      check("bh_valid",  32'(dif.instr_valid), 32'd0);
      push_fetch(8'd0);
      tick();
      pop_check("bh_fetch");

      // out-of-range target
      branch_valid = 1'b1;
      branch_target = 8'd200;
      tick();
      branch_valid = 1'b0;
      check("flt_fault",  32'(fault),           32'd1);
      check("flt_halted", 32'(halted),          32'd1);
      check("flt_valid",  32'(dif.instr_valid), 32'd0);
      check("flt_pc",     32'(pc),              32'd1);
      tick();
      check("flt_sticky", 32'(fault),           32'd1);
      check("flt_nofetch", 32'(dif.instr_valid), 32'd0);

      // asynchronous reset between edges
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_pc",     32'(pc),              32'd0);
      check("arst_addr",   32'(linenumber),      32'd0);
      check("arst_instr",  32'(dif.instr),       32'd0);
      check("arst_ipc",    32'(dif.instr_pc),    32'd0);
      check("arst_valid",  32'(dif.instr_valid), 32'd0);
      check("arst_halted", 32'(halted),          32'd0);
      check("arst_fault",  32'(fault),           32'd0);
      en = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      check("drain_valid", 32'(dif.instr_valid), 32'd0);
      check("drain_pc",    32'(pc),              32'd0);
      check("q_empty",     32'(exp_q.size()),    32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the cpu2 core: owns the program counter, drives the program ROM address and registers the returned instruction.
- Presents each instruction to the decoder through a valid/ready handshake.
- Accepts branch redirects and halt requests from the execute stage.
- Sits between the program ROM (combinational: `linenumber` -> `out` in the same cycle) and the decoder.

Parameters:
- ADDR_W, 8, width of PC / ROM address
- INSTR_W, 8, instruction width
- PROG_LEN, 64, number of valid program words; PC wraps to 0 after PROG_LEN-1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  fetch enable; 0 = no new fetches
- linenumber  out  ADDR_W  ROM address, always equal to pc
- rom_data  in  INSTR_W  ROM read data for linenumber (same cycle)
- instr  out  INSTR_W  registered instruction to decoder
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_pc are valid
- instr_ready  in  1  decoder accepts instr this cycle
- branch_valid  in  1  redirect request, one-cycle pulse
- branch_target  in  ADDR_W  redirect address
- halt  in  1  halt request, one-cycle pulse
- pc  out  ADDR_W  current program counter
- halted  out  1  fetch stopped (halt or fault)
- fault  out  1  sticky; out-of-range branch target seen

Behaviour:
- **Reset (rst=0, asynchronous):**
  - pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fault=0, state=RUN.
  - Reset asserted mid-operation discards any held instruction immediately.
- **Address path:** linenumber = pc, combinational, every cycle.
- **States:** RUN, HALTED.
- **RUN, accept:**
  - Condition: "slot free" = !instr_valid || instr_ready.
  - If en=1 and slot free, at the edge: instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=(pc==PROG_LEN-1)?0:pc+1.
  - Throughput is 1 instr/cycle with instr_ready held high.
- **RUN, stall:**
  - instr_valid=1 && instr_ready=0: instr, instr_pc, instr_valid and pc all hold.
  - The ROM address stays constant.
- **RUN, drain:** en=0 with slot free: instr_valid<=0; pc holds.
- **Latency:** first rising edge after rst release with en=1 gives instr_valid=1, instr=ROM[0].
- **Branch (highest priority after reset), branch_valid=1:**
  - If branch_target < PROG_LEN: pc<=branch_target and instr_valid<=0 (flush, regardless of instr_ready or stall). The fetch from the target occurs on the next cycle.
  - If branch_target >= PROG_LEN: fault<=1, halted<=1, instr_valid<=0, state<=HALTED; pc unchanged.
- **Halt, halt=1 and no branch_valid:**
  - Latch a pending-halt flag and stop issuing new fetches.
  - Once instr_valid=0, or the held instr is accepted (instr_valid && instr_ready), go to HALTED: halted=1, instr_valid=0.
  - pc holds the next unfetched address.
- **HALTED:**
  - No fetches; instr_valid=0.
  - Exits to RUN only on a valid branch_valid, which loads pc and clears halted.
  - fault stays set until reset.
  - A halt pulse received while already HALTED is ignored.
- **Simultaneous events:**
  - branch_valid with halt: branch wins and halt is dropped.
  - branch_valid with instr_ready: the held instr counts as consumed, then is flushed. Its valid drops the same edge.
- **PC arithmetic:**
  - Modulo PROG_LEN, never pc+1 overflow into unused ROM.
  - When PROG_LEN = 2^ADDR_W, natural wrap.

Decomposition:
- Shared cpu_pkg holds:
  - ADDR_W, INSTR_W, PROG_LEN constants.
  - Fetch state enum {RUN, HALTED}.
  - Instruction opcode field constants, also used by the decoder.
- No sub-module: PC/next-PC logic and output register are one always_ff + one always_comb.
- The ROM is instantiated beside fetch_unit at core top level, not inside it.

Test Plan:
- **Reset/stream:** bench ROM {0x8F,0x8B,0x85,0x9B,0x9D,0x97}, en=1, instr_ready=1 after rst release -> instr 0x8F,0x8B,0x85,0x9B on consecutive cycles; instr_pc 0,1,2,3.
- **Backpressure:** instr_ready=0 for 3 cycles while instr=0x8B -> instr, instr_pc=1, pc=2 and linenumber=2 all stable; release -> next instr 0x85.
- **Branch flush:** branch_valid with target=4 while instr=0x85 valid -> instr_valid=0 next cycle, then instr=0x9D, instr_pc=4.
- **Wrap:** PROG_LEN=6, stream past addr 5 -> instr_pc sequence 4,5,0,1 and instr 0x9D,0x97,0x8F,0x8B.
- **Halt/resume:**
  - halt while instr valid, instr_ready=0 -> no new fetch.
  - Accept -> halted=1, instr_valid=0, pc held.
  - branch_valid target=2 -> halted=0, instr=0x85.
- **Fault + async reset:**
  - branch_target=200 -> fault=1, halted=1.
  - rst pulsed low between edges -> all outputs 0 immediately, fault cleared.
